// File: rtl/odd_parity_frame_tx.sv
// odd_parity_frame_tx
// Accepts a DATA_W-bit word over valid/ready, latches its odd parity, and
// serialises it as start(0), data LSB-first, parity, stop(1), with every
// frame bit held for CLKS_PER_BIT cycles. Only one frame is in flight at a time.
module odd_parity_frame_tx #(
    parameter int DATA_W       = 3,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx_out,
    output logic              busy,
    output logic              parity_bit,
    output logic              frame_done
);

    // Width guards keep the counters at least one bit wide when a parameter is 1.
    localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int INDEX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [INDEX_W-1:0] INDEX_LAST = INDEX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [INDEX_W-1:0]  index_q, index_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                parity_q, parity_d;
    logic                tx_q, tx_d;
    logic                bit_end;
    logic                transfer;

    assign bit_end    = (timer_q == TIMER_LAST);
    assign in_ready   = (state_q == IDLE) && !rst;
    assign transfer   = in_valid && in_ready;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == STOP) && bit_end;
    assign tx_out     = tx_q;
    assign parity_bit = parity_q;

    // Next-state, bit timing and the registered line value for the next cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d  = state_q;
        timer_d  = bit_end ? '0 : timer_q + 1'b1;
        index_d  = index_q;
        shift_d  = shift_q;
        parity_d = parity_q;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                index_d = '0;
                if (transfer) begin
                    state_d  = START;
                    shift_d  = in_data;
                    parity_d = ~^in_data;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (index_q == INDEX_LAST) begin
                        state_d = PARITY;
                        index_d = '0;
                    end else begin
                        // Present the next payload bit at position 0.
                        index_d = index_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The line is registered, so it is derived from where the FSM is going;
        // this makes tx_out fall on the first cycle after the accepting edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    // State register with synchronous reset; a reset mid-frame drops the frame.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            index_q  <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            index_q  <= index_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_odd_parity_frame_tx.sv
// Self-checking bench for odd_parity_frame_tx (DATA_W=3, CLKS_PER_BIT=2).
module tb_odd_parity_frame_tx;

    localparam int DW        = 3;
    localparam int CPB       = 2;
    localparam int FRAME_LEN = (DW + 3) * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          tx_out;
    logic          busy;
    logic          parity_bit;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    odd_parity_frame_tx #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .tx_out     (tx_out),
        .busy       (busy),
        .parity_bit (parity_bit),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Expected line pattern is stored first-cycle-first (MSB = cycle 1).
    typedef struct {
        logic [DW-1:0]        data;
        logic                 par;
        logic [FRAME_LEN-1:0] frame;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: a word with an even number of ones needs a parity bit of 1.
    function automatic logic model_parity(input logic [DW-1:0] d);
        return (($countones(d) % 2) == 0);
    endfunction

    // Reference: list the frame bits, then stretch each one to CPB cycles.
    function automatic logic [FRAME_LEN-1:0] model_frame(input logic [DW-1:0] d);
        logic                 bits[$];
        logic [FRAME_LEN-1:0] f;
        int                   pos;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        bits.push_back(model_parity(d));
        bits.push_back(1'b1);
        f   = '0;
        pos = FRAME_LEN - 1;
        foreach (bits[k]) begin
            for (int c = 0; c < CPB; c++) begin
                f[pos] = bits[k];
                pos--;
            end
        end
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        check("ready_timeout", in_ready, 1);
    endtask

    task automatic idle_check(input string nm);
        check({nm, "_idle_tx"}, tx_out, 1);
        check({nm, "_idle_ready"}, in_ready, 1);
        check({nm, "_idle_busy"}, busy, 0);
        check({nm, "_idle_done"}, frame_done, 0);
    endtask

    // Called at the sample point just after the accepting edge; returns at
    // the sample point of the last frame cycle. pulse_at >= 0 raises a
    // one-cycle in_valid pulse at that frame cycle.
    task automatic capture_frame(input logic [DW-1:0] d, input logic [FRAME_LEN-1:0] exp,
                                 input logic exp_par, input string nm, input int pulse_at);
        logic [FRAME_LEN-1:0] got;
        int                   done_cnt = 0;
        int                   done_pos = -1;
        logic                 ready_seen = 1'b0;
        logic                 busy_low = 1'b0;
        check({nm, "_parity"}, parity_bit, exp_par);
        check({nm, "_odd_weight"}, $countones({d, parity_bit}) % 2, 1);
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i > 0) step();
            if (i == pulse_at) begin
                in_valid = 1'b1;
                in_data  = DW'($urandom);
            end else if (pulse_at >= 0 && i == pulse_at + 1) begin
                in_valid = 1'b0;
            end
            got[FRAME_LEN-1-i] = tx_out;
            if (frame_done) begin
                done_cnt++;
                done_pos = i;
            end
            if (in_ready) ready_seen = 1'b1;
            if (!busy) busy_low = 1'b1;
        end
        check({nm, "_frame"}, got, exp);
        check({nm, "_done_count"}, done_cnt, 1);
        check({nm, "_done_pos"}, done_pos, FRAME_LEN - 1);
        check({nm, "_ready_in_frame"}, ready_seen, 0);
        check({nm, "_busy_in_frame"}, busy_low, 0);
        check({nm, "_parity_hold"}, parity_bit, exp_par);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [FRAME_LEN-1:0] exp,
                        input logic exp_par, input string nm, input int pulse_at);
        in_valid = 1'b1;
        in_data  = d;
        wait_ready();
        step();
        in_valid = 1'b0;
        capture_frame(d, exp, exp_par, nm, pulse_at);
    endtask

    initial begin
        vecs[0] = '{3'b000, 1'b1, 12'b00_00_00_00_11_11};
        vecs[1] = '{3'b001, 1'b0, 12'b00_11_00_00_00_11};
        vecs[2] = '{3'b010, 1'b0, 12'b00_00_11_00_00_11};
        vecs[3] = '{3'b011, 1'b1, 12'b00_11_11_00_11_11};
        vecs[4] = '{3'b100, 1'b0, 12'b00_00_00_11_00_11};
        vecs[5] = '{3'b101, 1'b1, 12'b00_11_00_11_11_11};
        vecs[6] = '{3'b110, 1'b1, 12'b00_00_11_11_11_11};
        vecs[7] = '{3'b111, 1'b0, 12'b00_11_11_11_00_11};

        // Reset, then idle: the line stays high and nothing pulses.
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        step();
        step();
        check("rst_tx", tx_out, 1);
        check("rst_busy", busy, 0);
        check("rst_parity", parity_bit, 0);
        check("rst_done", frame_done, 0);
        check("rst_ready_low", in_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            idle_check("idle5");
        end

        // Single frame of 3'b000.
        send(vecs[0].data, vecs[0].frame, vecs[0].par, "w000", -1);
        step();
        idle_check("w000");

        // 3'b011 then 3'b111 with in_valid held: exactly one idle cycle between.
        in_valid = 1'b1;
        in_data  = 3'b011;
        wait_ready();
        step();
        in_data = 3'b111;
        capture_frame(3'b011, vecs[3].frame, vecs[3].par, "b2b_a", -1);
        step();
        idle_check("b2b_gap");
        step();
        in_valid = 1'b0;
        capture_frame(3'b111, vecs[7].frame, vecs[7].par, "b2b_b", -1);
        step();
        idle_check("b2b_b");

        // Table sweep over every word.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].data, vecs[i].frame, vecs[i].par, $sformatf("sweep%0d", i), -1);
            step();
        end

        // Reset on cycle 5 of a frame, with a word offered during reset.
        in_valid = 1'b1;
        in_data  = 3'b011;
        wait_ready();
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_no_done", frame_done, 0);
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 3'b110;
        #1;
        check("mid_ready_in_rst", in_ready, 0);
        step();
        check("mid_rst_tx", tx_out, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", frame_done, 0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_parity", parity_bit, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            idle_check("mid_after");
        end
        send(vecs[5].data, vecs[5].frame, vecs[5].par, "after_rst_101", -1);
        step();
        idle_check("after_rst_101");

        // A one-cycle in_valid pulse mid-frame must be ignored.
        send(3'b100, vecs[4].frame, vecs[4].par, "pulse", 5);
        for (int i = 0; i < 4; i++) begin
            step();
            idle_check("pulse_no_second");
        end

        // Randomised words and gaps against the reference model.
        for (int i = 0; i < 16; i++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            send(d, model_frame(d), model_parity(d), $sformatf("rand%0d", i), -1);
            repeat ($urandom_range(0, 3)) begin
                step();
                idle_check("rand_gap");
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
